demux_1_2_buf: RTL and testbench

//  Buffered 32-bit 1-to-2 demultiplexer; the steering counterpart of the datapath 2:1 MUX.

---
 rtl/demux_1_2_buf.sv | 88 ++++++++
 tb/tb_demux_1_2_buf.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1_2_buf.sv
// Buffered 1-to-2 demultiplexer: each accepted word is steered by sel into a 2-entry FIFO per output port.
// Optional per-port pop counters are enabled by defining DEMUX_CNT_EN.
module demux_1_2_buf #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 sel,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_0_data,
  output logic                 out_0_valid,
  input  logic                 out_0_ready,
  output logic [WIDTH-1:0]     out_1_data,
  output logic                 out_1_valid,
  input  logic                 out_1_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt_0,
  output logic [CNT_WIDTH-1:0] cnt_1
`endif
);

  logic [1:0]       count  [2];
  logic             wr_ptr [2];
  logic             rd_ptr [2];
  logic [WIDTH-1:0] mem    [2][2];
  logic [1:0]       push;
  logic [1:0]       pop;

  // Space is judged from registered state only, so a same-cycle pop never frees room for a push.
  assign in_ready = (count[sel] != 2'd2);

  always_comb begin
    push[0] = in_valid & in_ready & ~sel;
    push[1] = in_valid & in_ready &  sel;
    pop[0]  = out_0_valid & out_0_ready;
    pop[1]  = out_1_valid & out_1_ready;
  end

  assign out_0_valid = (count[0] != 2'd0);
  assign out_1_valid = (count[1] != 2'd0);
  assign out_0_data  = mem[0][rd_ptr[0]];
  assign out_1_data  = mem[1][rd_ptr[1]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        count[p]  <= 2'd0;
        wr_ptr[p] <= 1'b0;
        rd_ptr[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wr_ptr[p] <= ~wr_ptr[p];
        if (pop[p])  rd_ptr[p] <= ~rd_ptr[p];
        case ({push[p], pop[p]})
          2'b10:   count[p] <= count[p] + 2'd1;
          2'b01:   count[p] <= count[p] - 2'd1;
          default: count[p] <= count[p];
        endcase
      end
    end
  end

  // NOTE: storage is deliberately left out of reset; valid is derived from count, so stale words are never exposed.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= in_data;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_0 <= '0;
      cnt_1 <= '0;
    end else begin
      if (pop[0]) cnt_0 <= cnt_0 + 1'b1;
      if (pop[1]) cnt_1 <= cnt_1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1_2_buf.sv
// Directed self-checking bench for demux_1_2_buf; counter checks run only when DEMUX_CNT_EN is defined.
module tb_demux_1_2_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        sel;
  logic        in_ready;
  logic [31:0] out_0_data;
  logic        out_0_valid;
  logic        out_0_ready;
  logic [31:0] out_1_data;
  logic        out_1_valid;
  logic        out_1_ready;
`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_0;
  logic [15:0] cnt_1;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  demux_1_2_buf #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .sel         (sel),
    .in_ready    (in_ready),
    .out_0_data  (out_0_data),
    .out_0_valid (out_0_valid),
    .out_0_ready (out_0_ready),
    .out_1_data  (out_1_data),
    .out_1_valid (out_1_valid),
    .out_1_ready (out_1_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_0       (cnt_0),
    .cnt_1       (cnt_1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    in_valid = v;
    sel      = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 1'b0; in_data = '0;
    out_0_ready = 1'b0; out_1_ready = 1'b0;

    // 1: reset then idle
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_0_valid", 32'(out_0_valid), 32'd0);
    check("rst_out_1_valid", 32'(out_1_valid), 32'd0);
    check("rst_in_ready_s0", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b1, 32'h0);
    check("rst_in_ready_s1", 32'(in_ready), 32'd1);
`ifdef DEMUX_CNT_EN
    check("rst_cnt_0", 32'(cnt_0), 32'd0);
    check("rst_cnt_1", 32'(cnt_1), 32'd0);
`endif

    // 2: single word to port 0, popped the following cycle
    out_0_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h1111_1111);
    check("p0_push_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("p0_valid", 32'(out_0_valid), 32'd1);
    check("p0_data", out_0_data, 32'h1111_1111);
    check("p0_port1_idle", 32'(out_1_valid), 32'd0);
    tick();
    check("p0_popped", 32'(out_0_valid), 32'd0);
    out_0_ready = 1'b0;

    // 3: fill port 1 with A,B; C stalls
    drive(1'b1, 1'b1, 32'hA);
    tick();
    drive(1'b1, 1'b1, 32'hB);
    check("p1_ready_b", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 1'b1, 32'hC);
    check("p1_full_ready", 32'(in_ready), 32'd0);
    tick();
    check("p1_stall_ready", 32'(in_ready), 32'd0);
    check("p1_head_a", out_1_data, 32'hA);

    // 4: port 1 full, port 0 still accepts
    drive(1'b1, 1'b0, 32'hD);
    check("p0_ready_while_p1_full", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("p0_d_valid", 32'(out_0_valid), 32'd1);
    check("p0_d_data", out_0_data, 32'hD);
    check("p1_still_a", out_1_data, 32'hA);

    // 3 continued: pop in same cycle does not open space for C
    out_1_ready = 1'b1;
    drive(1'b1, 1'b1, 32'hC);
    check("p1_pop_no_space", 32'(in_ready), 32'd0);
    tick();
    check("p1_head_b", out_1_data, 32'hB);
    check("p1_ready_after_pop", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 1'b1, 32'h0);
    check("p1_head_c", out_1_data, 32'hC);
    check("p1_c_valid", 32'(out_1_valid), 32'd1);
    tick();
    check("p1_drained", 32'(out_1_valid), 32'd0);
    out_1_ready = 1'b0;

    // 5: port 0 holds D; push E with simultaneous pop keeps count at 1
    out_0_ready = 1'b1;
    drive(1'b1, 1'b0, 32'hE);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    check("p0_pushpop_valid", 32'(out_0_valid), 32'd1);
    check("p0_pushpop_data", out_0_data, 32'hE);
    tick();
    check("p0_count_was_1", 32'(out_0_valid), 32'd0);
    out_0_ready = 1'b0;

    // 6: both FIFOs full, then reset
    drive(1'b1, 1'b0, 32'h1); tick();
    drive(1'b1, 1'b0, 32'h2); tick();
    drive(1'b1, 1'b1, 32'h3); tick();
    drive(1'b1, 1'b1, 32'h4); tick();
    drive(1'b0, 1'b0, 32'h0);
    check("full_ready_s0", 32'(in_ready), 32'd0);
    drive(1'b0, 1'b1, 32'h0);
    check("full_ready_s1", 32'(in_ready), 32'd0);
    check("full_p1_head", out_1_data, 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_0_valid", 32'(out_0_valid), 32'd0);
    check("mid_rst_out_1_valid", 32'(out_1_valid), 32'd0);
    check("mid_rst_ready_s1", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b0, 32'h0);
    check("mid_rst_ready_s0", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 32'h55);
    tick();
    drive(1'b0, 1'b1, 32'h0);
    check("post_rst_p1_data", out_1_data, 32'h55);
    check("post_rst_p1_valid", 32'(out_1_valid), 32'd1);

`ifdef DEMUX_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("cnt_rst_cnt_0", 32'(cnt_0), 32'd0);
    // Streaming push+pop keeps port 0 at count 1; every pushed word is popped once.
    out_0_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 65539; i++) tick();
    drive(1'b0, 1'b0, 32'h0);
    tick(); tick();
    check("cnt_wrap_cnt_0", 32'(cnt_0), 32'd3);
    check("cnt_wrap_cnt_1", 32'(cnt_1), 32'd0);
    out_0_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
